// File: rtl/ramio_fifo.sv
// CPU-side RAM/IO bridge: typed byte/half/word accesses onto a byte-enabled cache port,
// plus LED register, status register and FIFO-buffered UART receive/transmit.

module ramio_uart_tx #(
  parameter int unsigned ClocksPerBit = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] data,
  output logic       tx,
  output logic       bsy
);
  localparam int unsigned CntW = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;

  logic            busy_q, busy_d;
  logic            armed_q, armed_d;
  logic [9:0]      shreg_q, shreg_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      armed_q <= 1'b1;
      shreg_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      armed_q <= armed_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  // A frame starts only after go has been low since the previous frame.
  always_comb begin
    busy_d  = busy_q;
    armed_d = armed_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (!go) armed_d = 1'b1;
    if (!busy_q) begin
      if (go && armed_q) begin
        busy_d  = 1'b1;
        armed_d = 1'b0;
        shreg_d = {1'b1, data, 1'b0};
        bit_d   = '0;
        cnt_d   = '0;
      end
    end else if (cnt_q == CntW'(ClocksPerBit - 1)) begin
      cnt_d   = '0;
      shreg_d = {1'b1, shreg_q[9:1]};
      if (bit_q == 4'd9) busy_d = 1'b0;
      else               bit_d  = bit_q + 4'd1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign tx  = shreg_q[0];
  assign bsy = busy_q;
endmodule

module ramio_uart_rx #(
  parameter int unsigned ClocksPerBit = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       go,
  output logic [7:0] data,
  output logic       data_ready
);
  localparam int unsigned CntW    = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
  localparam int unsigned HalfBit = (ClocksPerBit > 1) ? ClocksPerBit / 2 : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e       state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign rx_s = sync_q[1];

  // Bits are sampled mid-period; data_ready holds until the consumer drops go.
  always_comb begin
    sync_d  = {sync_q[0], rx};
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = ready_q;
    if (!go) ready_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CntW'(HalfBit - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CntW'(ClocksPerBit - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        if (cnt_q == CntW'(ClocksPerBit - 1)) begin
          state_d = RX_IDLE;
          if (rx_s) begin
            data_d  = shreg_q;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  assign data       = data_q;
  assign data_ready = ready_q;
endmodule

module ramio_fifo #(
  parameter int unsigned AddressBitWidth  = 32,
  parameter int unsigned DataBitWidth     = 32,
  parameter int unsigned ClockFrequencyHz = 20_250_000,
  parameter int unsigned BaudRate         = 9600,
  parameter int unsigned LedCount         = 4,
  parameter int unsigned RxFifoDepthLog2  = 4,
  parameter int unsigned TxFifoDepthLog2  = 4,
  parameter logic [AddressBitWidth-1:0] TopAddress     = '1,
  parameter logic [AddressBitWidth-1:0] AddressLed     = TopAddress,
  parameter logic [AddressBitWidth-1:0] AddressUartOut = TopAddress - AddressBitWidth'(1),
  parameter logic [AddressBitWidth-1:0] AddressUartIn  = TopAddress - AddressBitWidth'(2),
  parameter logic [AddressBitWidth-1:0] AddressStatus  = TopAddress - AddressBitWidth'(7)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [2:0]                 read_type,
  input  logic [1:0]                 write_type,
  input  logic [AddressBitWidth-1:0] address,
  input  logic [DataBitWidth-1:0]    data_in,
  output logic [DataBitWidth-1:0]    data_out,
  output logic                       data_out_ready,
  output logic                       busy,
  output logic [LedCount-1:0]        led,
  output logic                       uart_tx,
  input  logic                       uart_rx,
  output logic                       mem_enable,
  output logic [AddressBitWidth-1:0] mem_address,
  output logic [DataBitWidth-1:0]    mem_data_in,
  output logic [3:0]                 mem_write_enable,
  input  logic [DataBitWidth-1:0]    mem_data_out,
  input  logic                       mem_data_out_ready,
  input  logic                       mem_busy
);
  localparam int unsigned ClocksPerBit = ClockFrequencyHz / BaudRate;
  localparam int unsigned RxDepth      = 2 ** RxFifoDepthLog2;
  localparam int unsigned TxDepth      = 2 ** TxFifoDepthLog2;
  localparam int unsigned RxPw         = RxFifoDepthLog2 + 1;
  localparam int unsigned TxPw         = TxFifoDepthLog2 + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEND, TX_ACK} tx_state_e;

  logic [LedCount-1:0] led_q, led_d;
  logic                ovr_q, ovr_d, mis_q, mis_d;
  logic                rx_go_q, rx_go_d, tx_go_q, tx_go_d;
  tx_state_e           tx_state_q, tx_state_d;
  logic [7:0]          send_q, send_d;
  logic [RxPw-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt;
  logic [TxPw-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt;
  logic [7:0]          rx_mem [RxDepth];
  logic [7:0]          tx_mem [TxDepth];

  logic        rd, wr, hit_led, hit_out, hit_in, hit_st, io_hit, ram;
  logic        rx_empty, rx_full, tx_empty, tx_full, tx_idle;
  logic        rx_push, tx_push, mis, mis_evt;
  logic [1:0]  size;
  logic [7:0]  rx_head, tx_head, rd_byte;
  logic [15:0] rd_half;
  logic [31:0] status, io_rdata;
  logic [7:0]  urx_data;
  logic        urx_ready, utx_bsy;

  ramio_uart_rx #(.ClocksPerBit(ClocksPerBit)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(uart_rx), .go(rx_go_q),
    .data(urx_data), .data_ready(urx_ready)
  );

  ramio_uart_tx #(.ClocksPerBit(ClocksPerBit)) u_tx (
    .clk(clk), .rst_n(rst_n), .go(tx_go_q), .data(send_q),
    .tx(uart_tx), .bsy(utx_bsy)
  );

  assign rd      = read_type != 3'b000;
  assign wr      = write_type != 2'b00;
  assign hit_led = address == AddressLed;
  assign hit_out = address == AddressUartOut;
  assign hit_in  = address == AddressUartIn;
  assign hit_st  = address == AddressStatus;
  assign io_hit  = enable && (hit_led || hit_out || hit_in || hit_st);
  assign ram     = enable && !io_hit;

  assign rx_cnt   = rx_wr_q - rx_rd_q;
  assign tx_cnt   = tx_wr_q - tx_rd_q;
  assign rx_empty = rx_cnt == '0;
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == RxPw'(RxDepth);
  assign tx_full  = tx_cnt == TxPw'(TxDepth);
  assign tx_idle  = tx_empty && (tx_state_q == TX_IDLE);
  assign rx_head  = rx_mem[rx_rd_q[RxFifoDepthLog2-1:0]];
  assign tx_head  = tx_mem[tx_rd_q[TxFifoDepthLog2-1:0]];
  assign led      = led_q;

  assign status = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 3'b000,
                   tx_idle, mis_q, ovr_q, tx_full, !rx_empty};

  always_comb begin
    io_rdata = '0;
    if (hit_in)       io_rdata = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};
    else if (hit_out) io_rdata = (tx_state_q != TX_IDLE) ? {24'h0, send_q} : 32'hFFFF_FFFF;
    else if (hit_led) io_rdata = 32'(led_q);
    else if (hit_st)  io_rdata = status;
  end

  // Access width comes from the write type when writing, else the read type.
  assign size = wr ? write_type : read_type[1:0];
  assign mis  = ((size == 2'b10) && address[0]) || ((size == 2'b11) && (address[1:0] != 2'b00));

  always_comb begin
    mem_enable       = 1'b0;
    mem_address      = {address[AddressBitWidth-1:2], 2'b00};
    mem_data_in      = '0;
    mem_write_enable = 4'b0000;
    data_out         = '0;
    data_out_ready   = 1'b0;
    busy             = 1'b0;
    mis_evt          = 1'b0;
    rd_byte          = mem_data_out[{address[1:0], 3'b000} +: 8];
    rd_half          = address[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    if (ram) begin
      mem_enable     = 1'b1;
      busy           = mem_busy;
      data_out_ready = mem_data_out_ready;
      if (mis) begin
        mis_evt = (rd || wr) && !mem_busy;
      end else begin
        if (wr) begin
          case (write_type)
            2'b01: begin
              mem_write_enable = 4'b0001 << address[1:0];
              mem_data_in      = {24'h0, data_in[7:0]} << {address[1:0], 3'b000};
            end
            2'b10: begin
              mem_write_enable = address[1] ? 4'b1100 : 4'b0011;
              mem_data_in      = address[1] ? {data_in[15:0], 16'h0} : {16'h0, data_in[15:0]};
            end
            default: begin
              mem_write_enable = 4'b1111;
              mem_data_in      = data_in;
            end
          endcase
        end
        if (rd) begin
          case (read_type[1:0])
            2'b01:   data_out = {{24{read_type[2] & rd_byte[7]}}, rd_byte};
            2'b10:   data_out = {{16{read_type[2] & rd_half[15]}}, rd_half};
            2'b11:   data_out = mem_data_out;
            default: data_out = '0;
          endcase
        end
      end
    end else if (io_hit) begin
      data_out_ready = 1'b1;
      busy           = wr && hit_out && tx_full;
      if (rd) data_out = io_rdata;
    end
  end

  // Register updates, FIFO pointers and the transmit sequencer.
  always_comb begin
    led_d      = led_q;
    ovr_d      = ovr_q;
    mis_d      = mis_q;
    rx_go_d    = 1'b1;
    tx_go_d    = tx_go_q;
    tx_state_d = tx_state_q;
    send_d     = send_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    rx_push    = 1'b0;
    tx_push    = 1'b0;
    if (enable && wr && hit_led) led_d = data_in[LedCount-1:0];
    if (enable && wr && hit_st) begin
      if (data_in[2]) ovr_d = 1'b0;
      if (data_in[3]) mis_d = 1'b0;
    end
    if (mis_evt) mis_d = 1'b1;
    // Fullness is judged before any same-edge CPU pop, so an arriving byte can still overrun.
    if (urx_ready && rx_go_q) begin
      rx_go_d = 1'b0;
      if (rx_full) begin
        ovr_d = 1'b1;
      end else begin
        rx_push = 1'b1;
        rx_wr_d = rx_wr_q + RxPw'(1);
      end
    end
    if (enable && rd && hit_in && !rx_empty) rx_rd_d = rx_rd_q + RxPw'(1);
    if (enable && wr && hit_out && !tx_full) begin
      tx_push = 1'b1;
      tx_wr_d = tx_wr_q + TxPw'(1);
    end
    case (tx_state_q)
      TX_IDLE: begin
        tx_go_d = 1'b0;
        if (!tx_empty) begin
          send_d     = tx_head;
          tx_rd_d    = tx_rd_q + TxPw'(1);
          tx_go_d    = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_go_d    = 1'b1;
        tx_state_d = TX_SEND;
      end
      TX_SEND: begin
        if (!utx_bsy) begin
          tx_go_d    = 1'b0;
          tx_state_d = TX_ACK;
        end
      end
      default: begin
        tx_go_d    = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '1;
      ovr_q      <= 1'b0;
      mis_q      <= 1'b0;
      rx_go_q    <= 1'b1;
      tx_go_q    <= 1'b0;
      tx_state_q <= TX_IDLE;
      send_q     <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
    end else begin
      led_q      <= led_d;
      ovr_q      <= ovr_d;
      mis_q      <= mis_d;
      rx_go_q    <= rx_go_d;
      tx_go_q    <= tx_go_d;
      tx_state_q <= tx_state_d;
      send_q     <= send_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RxFifoDepthLog2-1:0]] <= urx_data;
    if (tx_push) tx_mem[tx_wr_q[TxFifoDepthLog2-1:0]] <= data_in[7:0];
  end
endmodule

// File: tb/tb_ramio_fifo.sv
// Directed bench for ramio_fifo: register map, UART FIFOs, RAM lane mapping, reset.

module tb_ramio_fifo;
  localparam logic [31:0] A_LED = 32'hFFFF_FFFF;
  localparam logic [31:0] A_OUT = 32'hFFFF_FFFE;
  localparam logic [31:0] A_IN  = 32'hFFFF_FFFD;
  localparam logic [31:0] A_ST  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  read_type;
  logic [1:0]  write_type;
  logic [31:0] address, data_in, data_out;
  logic        data_out_ready, busy;
  logic [3:0]  led;
  logic        uart_tx, uart_rx;
  logic        mem_enable;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [3:0]  mem_write_enable;
  logic        mem_data_out_ready, mem_busy;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] rxq[$];

  ramio_fifo #(
    .ClockFrequencyHz(8),
    .BaudRate(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read_type(read_type),
    .write_type(write_type), .address(address), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
    .led(led), .uart_tx(uart_tx), .uart_rx(uart_rx),
    .mem_enable(mem_enable), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
    .mem_data_out_ready(mem_data_out_ready), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [2:0] rt, input logic [1:0] wt, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge clk);
    enable = 1'b1; read_type = rt; write_type = wt; address = a; data_in = d;
    #1;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("busy_timeout", {31'b0, busy}, 32'h0);
    q = data_out;
    @(posedge clk);
    #1;
    enable = 1'b0; read_type = 3'b000; write_type = 2'b00;
  endtask

  task automatic wait_tx_idle(output logic [31:0] st);
    int n;
    n  = 0;
    st = '0;
    while (!st[4] && n < 4000) begin
      cpu(3'b011, 2'b00, A_ST, 32'h0, st);
      n++;
    end
    if (!st[4]) chk("tx_idle_timeout", st, 32'h10);
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_rx = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(8);
    end
    uart_rx = 1'b1;
    wait_cyc(16);
  endtask

  // Serial monitor on uart_tx: 8 clocks per bit, sampled mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (8) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (8) @(negedge clk);
      rxq.push_back(b);
    end
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; enable = 1'b0; read_type = 3'b000; write_type = 2'b00;
    address = '0; data_in = '0; uart_rx = 1'b1;
    mem_data_out = '0; mem_data_out_ready = 1'b0; mem_busy = 1'b0;
    wait_cyc(3);
    chk("reset_led", {28'h0, led}, 32'hF);
    chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    rst_n = 1'b1;
    wait_cyc(2);
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("reset_status", r, 32'h0000_0010);

    cpu(3'b000, 2'b01, A_LED, 32'h5, r);
    chk("led_write", {28'h0, led}, 32'h5);
    cpu(3'b001, 2'b00, A_LED, 32'h0, r);
    chk("led_read", r, 32'h5);

    // Three bytes back to back: one in flight, two queued.
    cpu(3'b000, 2'b01, A_OUT, 32'h41, r);
    cpu(3'b000, 2'b01, A_OUT, 32'h42, r);
    cpu(3'b000, 2'b01, A_OUT, 32'h43, r);
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("tx_queued_status", r, 32'h0002_0000);
    cpu(3'b001, 2'b00, A_OUT, 32'h0, r);
    chk("tx_shifting_byte", r, 32'h41);
    wait_tx_idle(r);
    chk("tx_done_status", r, 32'h10);
    chk("tx_abc_count", 32'(rxq.size()), 32'd3);
    if (rxq.size() == 3) begin
      chk("tx_a", {24'h0, rxq[0]}, 32'h41);
      chk("tx_b", {24'h0, rxq[1]}, 32'h42);
      chk("tx_c", {24'h0, rxq[2]}, 32'h43);
    end
    rxq.delete();

    // TX back-pressure: fill the FIFO while the first byte is on the wire.
    cpu(3'b000, 2'b01, A_OUT, 32'h60, r);
    wait_cyc(5);
    for (int i = 0; i < 16; i++) cpu(3'b000, 2'b01, A_OUT, 32'h61 + i, r);
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("tx_full_status", r, 32'h0010_0002);
    @(negedge clk);
    enable = 1'b1; read_type = 3'b000; write_type = 2'b01; address = A_OUT; data_in = 32'h71;
    #1;
    chk("tx_backpressure_busy", {31'h0, busy}, 32'h1);
    cpu(3'b000, 2'b01, A_OUT, 32'h71, r);
    wait_tx_idle(r);
    chk("tx_fill_idle_status", r, 32'h10);
    chk("tx_fill_count", 32'(rxq.size()), 32'd18);
    if (rxq.size() == 18)
      for (int i = 0; i < 18; i++) chk($sformatf("tx_fill_byte%0d", i), {24'h0, rxq[i]}, 32'h60 + i);

    // RX overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) send_rx(8'(i));
    wait_cyc(10);
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("rx_full_status", r, 32'h0000_1015);
    for (int i = 0; i < 16; i++) begin
      cpu(3'b001, 2'b00, A_IN, 32'h0, r);
      chk($sformatf("rx_byte%0d", i), r, i);
    end
    cpu(3'b001, 2'b00, A_IN, 32'h0, r);
    chk("rx_empty_read", r, 32'hFFFF_FFFF);
    cpu(3'b000, 2'b11, A_ST, 32'h4, r);
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("rx_w1c_status", r, 32'h10);

    // RAM lane mapping and extension.
    mem_data_out = 32'h8001_0000; mem_data_out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1; read_type = 3'b000; write_type = 2'b10; address = 32'h102; data_in = 32'hBEEF;
    #1;
    chk("sh_enable", {31'h0, mem_enable}, 32'h1);
    chk("sh_we", {28'h0, mem_write_enable}, 32'hC);
    chk("sh_data", mem_data_in, 32'hBEEF_0000);
    chk("sh_addr", mem_address, 32'h100);
    wait_cyc(1);
    enable = 1'b0; write_type = 2'b00;
    cpu(3'b110, 2'b00, 32'h102, 32'h0, r);
    chk("lh_signed", r, 32'hFFFF_8001);
    cpu(3'b010, 2'b00, 32'h102, 32'h0, r);
    chk("lhu", r, 32'h0000_8001);
    cpu(3'b101, 2'b00, 32'h103, 32'h0, r);
    chk("lb_signed", r, 32'hFFFF_FF80);

    // Misaligned half read.
    @(negedge clk);
    enable = 1'b1; read_type = 3'b110; write_type = 2'b00; address = 32'h101;
    #1;
    chk("mis_data", data_out, 32'h0);
    chk("mis_we", {28'h0, mem_write_enable}, 32'h0);
    wait_cyc(1);
    enable = 1'b0; read_type = 3'b000;
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("mis_status", r, 32'h18);

    // Asynchronous reset in the middle of a frame.
    cpu(3'b000, 2'b01, A_OUT, 32'h55, r);
    wait_cyc(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", {31'h0, uart_tx}, 32'h1);
    chk("midframe_reset_led", {28'h0, led}, 32'hF);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    cpu(3'b011, 2'b00, A_ST, 32'h0, r);
    chk("post_reset_status", r, 32'h10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
